// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with a valid handshake and an accumulator.
// Adds a saturating completed-op counter, a zero flag and a sticky overrun flag.

module logic_unit_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~a;
            3'd4:    y = ~(a & b);
            3'd5:    y = ~(a | b);
            3'd6:    y = ~(a ^ b);
            default: y = b;
        endcase
    end
endmodule

module logic_unit_pipe #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic                 acc_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clear_acc,
    output logic [WIDTH-1:0]     result,
    output logic                 out_valid,
    output logic                 zero,
    output logic [WIDTH-1:0]     acc,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 overrun
);
    logic                          accept;
    logic                          busy;
    logic [WIDTH-1:0]              opa;
    logic [WIDTH-1:0]              alu_y;

    // Registered stages 1..STAGES; stage STAGES is the output register.
    logic [STAGES:1]               vld_q;
    logic [STAGES:1]               am_q;
    logic [STAGES:1][WIDTH-1:0]    res_q;

    // Stage 0 is the combinational issue slot, the rest mirror the registers.
    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0]               am_pipe;
    logic [STAGES:0][WIDTH-1:0]    res_pipe;

    assign opa = acc_mode ? acc : a;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic_unit_lane u_lane (
                .op (op),
                .a  (opa[gi]),
                .b  (b[gi]),
                .y  (alu_y[gi])
            );
        end
    endgenerate

    // An acc_mode op still ahead of the output register has not written acc yet.
    always_comb begin
        busy = 1'b0;
        for (int k = 1; k < STAGES; k++)
            busy = busy | (vld_q[k] & am_q[k]);
    end

    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready;

    always_comb begin
        vld_pipe[0] = accept;
        am_pipe[0]  = acc_mode;
        res_pipe[0] = alu_y;
        for (int k = 1; k <= STAGES; k++) begin
            vld_pipe[k] = vld_q[k];
            am_pipe[k]  = am_q[k];
            res_pipe[k] = res_q[k];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            am_q     <= '0;
            res_q    <= '0;
            acc      <= '0;
            op_count <= '0;
            zero     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                vld_q[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) begin
                    res_q[k] <= res_pipe[k-1];
                    am_q[k]  <= am_pipe[k-1];
                end
            end

            // Writeback happens on the edge that loads the output register.
            if (vld_pipe[STAGES-1]) begin
                zero <= (res_pipe[STAGES-1] == '0);
                if (op_count != '1)
                    op_count <= op_count + CNT_WIDTH'(1);
            end

            if (clear_acc)
                acc <= '0;
            else if (vld_pipe[STAGES-1])
                acc <= res_pipe[STAGES-1];

            if (in_valid && !in_ready)
                overrun <= 1'b1;
        end
    end

    assign out_valid = vld_q[STAGES];
    assign result    = res_q[STAGES];
endmodule
